// File: rtl/i2s_rx_pkg.sv
// Shared audio definitions for the I2S receiver: receive FSM states and default sizing.
package i2s_rx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam logic [31:0] DEFAULT_HYST  = 32'h0000_0800;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for N asynchronous inputs, with a rising-edge strobe on bit 0.
module i2s_sync #(
    parameter int unsigned N = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] i_async,
    output logic [N-1:0] o_sync,
    output logic         o_rise_c
);

    logic [N-1:0] r_meta;
    logic [N-1:0] r_sync;
    logic         r_prev;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync[0];
        end
    end

    assign o_sync   = r_sync;
    assign o_rise_c = r_sync[0] & ~r_prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises left/right words from a codec and derives a tape EAR bit
// from the left channel with hysteresis.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter logic [31:0] HYST  = DEFAULT_HYST
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sck,
    input  logic             lr,
    input  logic             d,
    output logic [WIDTH-1:0] ldata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             err,
    output logic             ear
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2:0]       w_sync;
    logic             w_rise;
    logic             w_lr;
    logic             w_d;
    logic             w_room;
    logic             w_trans;
    logic             w_full;
    logic [CW-1:0]    w_cnt_nx;
    logic [WIDTH-1:0] w_word_nx;
    logic signed [33:0] w_l_ext;
    logic signed [33:0] w_hyst;

    rx_state_e        r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_hold;
    logic             r_lr_prev;

    // bit 0 = sck carries the edge strobe; lr and d share the same latency
    i2s_sync #(.N(3)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .i_async  ({d, lr, sck}),
        .o_sync   (w_sync),
        .o_rise_c (w_rise)
    );

    assign w_lr      = w_sync[1];
    assign w_d       = w_sync[2];
    assign w_room    = (r_cnt < CW'(WIDTH));
    assign w_word_nx = w_room ? {r_word[WIDTH-2:0], w_d} : r_word;
    assign w_cnt_nx  = w_room ? (r_cnt + CW'(1)) : r_cnt;
    assign w_trans   = w_rise && (w_lr != r_lr_prev);
    assign w_full    = (w_cnt_nx == CW'(WIDTH));
    assign w_l_ext   = 34'(signed'(ldata));
    assign w_hyst    = $signed({2'b00, HYST});

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_HUNT;
            r_cnt     <= '0;
            r_word    <= '0;
            r_hold    <= '0;
            r_lr_prev <= 1'b0;
            ldata     <= '0;
            rdata     <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            ear       <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;

            if (valid) begin
                if (w_l_ext > w_hyst) begin
                    ear <= 1'b1;
                end else if (w_l_ext < -w_hyst) begin
                    ear <= 1'b0;
                end
            end

            if (w_rise) begin
                r_lr_prev <= w_lr;
                if (w_trans) begin
                    // the bit on a word-select change still belongs to the old word
                    r_cnt  <= '0;
                    r_word <= '0;
                    case (r_state)
                        ST_HUNT: begin
                            if (!w_lr) begin
                                r_state <= ST_LEFT;
                            end
                        end
                        ST_LEFT: begin
                            if (w_lr && w_full) begin
                                r_hold  <= w_word_nx;
                                r_state <= ST_RIGHT;
                            end else begin
                                err     <= 1'b1;
                                r_state <= ST_HUNT;
                            end
                        end
                        ST_RIGHT: begin
                            if (!w_lr && w_full) begin
                                ldata   <= r_hold;
                                rdata   <= w_word_nx;
                                valid   <= 1'b1;
                                r_state <= ST_LEFT;
                            end else begin
                                err     <= 1'b1;
                                r_state <= ST_HUNT;
                            end
                        end
                        default: r_state <= ST_HUNT;
                    endcase
                end else begin
                    r_cnt  <= w_cnt_nx;
                    r_word <= w_word_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: builds I2S bit streams, queues expected frames, checks on valid.
module tb_i2s_rx;

    logic        clock;
    logic        reset;
    logic        sck;
    logic        lr;
    logic        d;
    logic [15:0] ldata;
    logic [15:0] rdata;
    logic        valid;
    logic        err;
    logic        ear;

    i2s_rx dut (
        .clock (clock),
        .reset (reset),
        .sck   (sck),
        .lr    (lr),
        .d     (d),
        .ldata (ldata),
        .rdata (rdata),
        .valid (valid),
        .err   (err),
        .ear   (ear)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        e;
    } exp_t;

    exp_t sb[$];
    logic bit_d[$];
    logic bit_c[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   err_cnt = 0;
    logic model_ear;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // channel word, MSB first; the one-bit lr delay is applied at playback
    task automatic add_word(input logic c, input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_d.push_back(w[i]);
            bit_c.push_back(c);
        end
    endtask

    task automatic push_frame(input logic [31:0] lw, input logic [31:0] rw, input int n);
        exp_t        e;
        logic [31:0] lt;
        logic [31:0] rt;
        int          v;
        add_word(1'b0, lw, n);
        add_word(1'b1, rw, n);
        lt = (n > 16) ? (lw >> (n - 16)) : lw;
        rt = (n > 16) ? (rw >> (n - 16)) : rw;
        e.l = lt[15:0];
        e.r = rt[15:0];
        v = int'($signed(e.l));
        if (v > 2048) model_ear = 1'b1;
        else if (v < -2048) model_ear = 1'b0;
        e.e = model_ear;
        sb.push_back(e);
    endtask

    // one sck period = 4 clocks (clock/4); lr leads the data by one bit
    task automatic play(input int from, input int to);
        for (int k = from; k < to; k++) begin
            sck = 1'b0;
            d   = bit_d[k];
            lr  = (k + 1 < bit_c.size()) ? bit_c[k + 1] : bit_c[k];
            repeat (2) @(negedge clock);
            sck = 1'b1;
            repeat (2) @(negedge clock);
        end
        sck = 1'b0;
    endtask

    task automatic new_stream();
        bit_d.delete();
        bit_c.delete();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check({tag, "_rst_ldata"}, 32'(ldata), 32'h0);
        check({tag, "_rst_rdata"}, 32'(rdata), 32'h0);
        check({tag, "_rst_valid"}, 32'(valid), 32'h0);
        check({tag, "_rst_err"},   32'(err),   32'h0);
        check({tag, "_rst_ear"},   32'(ear),   32'h0);
        reset = 1'b1;
        model_ear = 1'b0;
        @(negedge clock);
    endtask

    task automatic drain(input string tag, input int base_err, input int exp_err);
        repeat (20) @(negedge clock);
        check({tag, "_sb_left"}, 32'(sb.size()), 32'h0);
        check({tag, "_err_cnt"}, 32'(err_cnt - base_err), 32'(exp_err));
        sb.delete();
    endtask

    always @(negedge clock) begin
        if (reset && err) err_cnt <= err_cnt + 1;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("ldata", 32'(ldata), 32'(e.l));
                    check("rdata", 32'(rdata), 32'(e.r));
                    @(negedge clock);
                    check("ear", 32'(ear), 32'(e.e));
                    check("valid_width", 32'(valid), 32'h0);
                end
            end
        end
    end

    initial begin
        int base;
        clock = 1'b0;
        reset = 1'b0;
        sck   = 1'b0;
        lr    = 1'b0;
        d     = 1'b0;
        model_ear = 1'b0;

        // basic frames plus hysteresis sequence
        do_reset("s1");
        base = err_cnt;
        new_stream();
        add_word(1'b1, 32'h5555, 16);
        push_frame(32'h1234, 32'hABCD, 16);
        push_frame(32'h1000, 32'h1111, 16);
        push_frame(32'h0400, 32'h2222, 16);
        push_frame(32'hF000, 32'h3333, 16);
        add_word(1'b0, 32'h0, 16);
        play(0, bit_d.size());
        drain("s1", base, 0);

        // 24-bit words truncated to 16
        do_reset("s2");
        base = err_cnt;
        new_stream();
        add_word(1'b1, 32'h00AA_AAAA, 24);
        push_frame(32'h0012_3456, 32'h0089_ABCD, 24);
        add_word(1'b0, 32'h0, 24);
        play(0, bit_d.size());
        drain("s2", base, 0);

        // short left word, then a good frame
        do_reset("s3");
        base = err_cnt;
        new_stream();
        add_word(1'b1, 32'h0F0F, 16);
        add_word(1'b0, 32'h00A5, 8);
        add_word(1'b1, 32'h1111, 16);
        push_frame(32'h0900, 32'h7777, 16);
        add_word(1'b0, 32'h0, 16);
        play(0, bit_d.size());
        drain("s3", base, 1);

        // start mid-right, reset mid-left, recover after a full pair
        do_reset("s4");
        base = err_cnt;
        new_stream();
        add_word(1'b1, 32'h0015, 5);
        push_frame(32'h7FFF, 32'h0001, 16);
        add_word(1'b0, 32'hCAFE, 16);
        add_word(1'b1, 32'hBEEF, 16);
        model_ear = 1'b0;
        push_frame(32'h2468, 32'h1357, 16);
        add_word(1'b0, 32'h0, 16);
        play(0, 45);
        repeat (6) @(negedge clock);
        check("s4_pre_reset_sb", 32'(sb.size()), 32'h1);
        do_reset("s4_mid");
        play(45, bit_d.size());
        drain("s4", base, 0);

        // back-to-back random frames
        do_reset("s5");
        base = err_cnt;
        new_stream();
        add_word(1'b1, 32'h0, 16);
        for (int i = 0; i < 8; i++) begin
            push_frame(32'($urandom_range(0, 16'hFFFF)), 32'($urandom_range(0, 16'hFFFF)), 16);
        end
        add_word(1'b0, 32'h0, 16);
        play(0, bit_d.size());
        drain("s5", base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 16; stored bits per channel, 8..32.
REQ-002 SHALL have parameter HYST, default 16'h0800; EAR hysteresis threshold, signed magnitude in WIDTH-bit units.
REQ-003 SHALL have port clock  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-low reset.
REQ-005 SHALL have port sck  input  1  I2S bit clock from codec, asynchronous.
REQ-006 SHALL have port lr  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
REQ-007 SHALL have port d  input  1  I2S serial data (codec ADC out), asynchronous, MSB first.
REQ-008 SHALL have port ldata  output  WIDTH  last complete left sample, two's complement.
REQ-009 SHALL have port rdata  output  WIDTH  last complete right sample, two's complement.
REQ-010 SHALL have port valid  output  1  one-cycle pulse when ldata/rdata update together.
REQ-011 SHALL have port err  output  1  one-cycle pulse on a short channel word.
REQ-012 SHALL have port ear  output  1  tape EAR bit derived from the left channel with hysteresis.

Function
REQ-013 sck, lr and d SHALL each pass through a 2-flop synchronizer; a sck rise SHALL be detected as synced sck=1 while the previous synced value was 0.
REQ-014 On each detected sck rise, lr and d SHALL be sampled; lr at this rise is compared with lr at the previous rise ("transition rise" when they differ).
REQ-015 Non-transition rise: when bit count < WIDTH, d SHALL shift into the word LSB-first-in (MSB ends at top) and the count SHALL increment; otherwise the bit SHALL be discarded (truncation of longer words).
REQ-016 Transition rise: the bit SHALL belong to the old word (I2S one-bit delay) and is shifted under the rule of REQ-015; the old word SHALL be complete when count reaches WIDTH; count then clears to 0.
REQ-017 The FSM SHALL have states HUNT, LEFT, RIGHT.
REQ-018 HUNT: on a transition rise with new lr=0, go to LEFT; no word is committed.
REQ-019 LEFT: on a transition rise with new lr=1, a complete word SHALL be stored in an internal left holding register and go to RIGHT; an incomplete word SHALL pulse err and go to HUNT.
REQ-020 RIGHT: on a transition rise with new lr=0, a complete word SHALL load ldata from the holding register and rdata from the word, pulse valid in the following clock cycle, and go to LEFT; an incomplete word SHALL pulse err and go to HUNT.
REQ-021 ldata/rdata SHALL hold their value between valid pulses.
REQ-022 On a valid pulse, ear SHALL become 1 when signed ldata > +HYST, 0 when < -HYST, and otherwise hold.
REQ-023 Supported frame: 8..32 sck rises per channel; sck at most clock/4.

Reset
REQ-024 While reset=0: state HUNT, count 0, shift/holding registers 0, ldata=0, rdata=0, valid=0, err=0, ear=0, synchronizers 0.
REQ-025 Reset released mid-frame SHALL discard the partial frame; the first valid SHALL follow only a complete left+right pair.

Structure
REQ-026 State encoding (HUNT/LEFT/RIGHT) and the default WIDTH/HYST constants SHALL live in a shared audio package.
REQ-027 The synchronizer plus rise detector SHALL be the sub-module i2s_sync, instanced for sck (with edge output) and used for lr and d.

Verification
REQ-028 16-bit words, 32 sck per frame, L=16'h1234, R=16'hABCD -> one valid, ldata=16'h1234, rdata=16'hABCD, err=0.
REQ-029 WIDTH=16, 24-bit words L=24'h123456, R=24'h89ABCD -> ldata=16'h1234, rdata=16'h89AB.
REQ-030 Left channel of only 8 bits -> err pulse, no valid, state HUNT; the next good frame gives valid.
REQ-031 HYST=16'h0800; left sequence 16'h1000, 16'h0400, 16'hF000 -> ear 1, 1, 0.
REQ-032 Stream start mid-right-channel, then reset pulsed mid-left word -> outputs 0 during reset; first valid only after the next full L+R pair.
REQ-033 Back-to-back frames at sck=clock/4 -> valid on every frame, no err, one valid per frame.
